// File: rtl/tpc_pkg.sv
// Shared constants, load-DMA state encoding and AXI burst sizing for the TPC.
package tpc_pkg;
    localparam int AXI_ADDR_W     = 40;
    localparam int LOCAL_ADDR_W   = 20;
    localparam int SRAM_WIDTH     = 256;
    localparam int BYTES_PER_BEAT = 32;
    localparam int PAGE_BYTES     = 4096;
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
    localparam int PAGE_SHIFT     = $clog2(PAGE_BYTES);

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_ADDR,
        LD_DATA,
        LD_DRAIN,
        LD_DONE
    } ld_state_e;

    // AXI bursts may not cross a 4 KB page, so clip to the beats left in the page.
    function automatic logic [15:0] burst_beats(input logic [PAGE_SHIFT-1:0] page_off,
                                                input logic [15:0] remaining,
                                                input logic [15:0] max_burst);
        logic [15:0] to_page;
        logic [15:0] beats;
        to_page = 16'(PAGE_BYTES / BYTES_PER_BEAT) - 16'(page_off >> BEAT_SHIFT);
        beats   = remaining;
        if (beats > max_burst) beats = max_burst;
        if (beats > to_page) beats = to_page;
        return beats;
    endfunction
endpackage

// File: rtl/tpc_sync_fifo.sv
// Show-ahead synchronous FIFO; a write appears on rd_dat one cycle later.
// Push is accepted when not full, or when full with a simultaneous pop.
module tpc_sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_dat  = mem[rd_ptr];
    assign do_pop  = rd_rdy && !empty;
    assign do_push = wr_vld && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tpc_load_dma.sv
// Loads DRAM words over AXI4 reads into TPC SRAM/instr_mem through the noc_rx port.
// First noc_rx_valid 3 cycles after accept plus read latency; AR held back until the FIFO can absorb a whole burst.
module tpc_load_dma #(
    parameter int SRAM_WIDTH   = tpc_pkg::SRAM_WIDTH,
    parameter int AXI_ADDR_W   = tpc_pkg::AXI_ADDR_W,
    parameter int LOCAL_ADDR_W = tpc_pkg::LOCAL_ADDR_W,
    parameter int MAX_BURST    = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AXI_ADDR_W-1:0]   cmd_src_addr,
    input  logic [LOCAL_ADDR_W-1:0] cmd_dst_addr,
    input  logic [15:0]             cmd_len,
    input  logic                    cmd_is_instr,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [AXI_ADDR_W-1:0]   axi_araddr,
    output logic [7:0]              axi_arlen,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [SRAM_WIDTH-1:0]   axi_rdata,
    input  logic                    axi_rlast,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,
    output logic [SRAM_WIDTH-1:0]   noc_rx_data,
    output logic [LOCAL_ADDR_W-1:0] noc_rx_addr,
    output logic                    noc_rx_is_instr,
    output logic                    noc_rx_valid,
    input  logic                    noc_rx_ready
);
    import tpc_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    ld_state_e               state;
    logic [15:0]             remaining;
    logic [8:0]              burst_left;
    logic [LOCAL_ADDR_W-1:0] noc_addr;
    logic                    is_instr;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [SRAM_WIDTH-1:0]   fifo_head;
    logic                    push;
    logic                    pop;
    logic                    last_beat;
    logic [16:0]             count_next;
    logic [16:0]             free_next;
    logic [15:0]             nb_cmd;
    logic [15:0]             nb_cur;
    logic [15:0]             nb_adv;
    logic [AXI_ADDR_W-1:0]   src_adv;

    tpc_sync_fifo #(.WIDTH(SRAM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_dat (axi_rdata),
        .rd_rdy (pop),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign axi_rready      = (state == LD_DATA) && !fifo_full;
    assign push            = axi_rvalid && axi_rready;
    assign noc_rx_valid    = !fifo_empty;
    assign pop             = noc_rx_valid && noc_rx_ready;
    assign noc_rx_data     = fifo_empty ? '0 : fifo_head;
    assign noc_rx_addr     = noc_addr;
    assign noc_rx_is_instr = is_instr;
    assign last_beat       = push && (burst_left == 9'd1);

    // Occupancy after this edge, so an AR can go out right after the last R beat.
    assign count_next = 17'(fifo_count) + 17'(push) - 17'(pop);
    assign free_next  = 17'(FIFO_DEPTH) - count_next;
    assign src_adv    = axi_araddr + ((AXI_ADDR_W'(axi_arlen) + AXI_ADDR_W'(1)) << BEAT_SHIFT);
    assign nb_cmd     = burst_beats(cmd_src_addr[PAGE_SHIFT-1:0], cmd_len, 16'(MAX_BURST));
    assign nb_cur     = burst_beats(axi_araddr[PAGE_SHIFT-1:0], remaining, 16'(MAX_BURST));
    assign nb_adv     = burst_beats(src_adv[PAGE_SHIFT-1:0], remaining, 16'(MAX_BURST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LD_IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_araddr  <= '0;
            axi_arlen   <= '0;
            remaining   <= '0;
            burst_left  <= '0;
            noc_addr    <= '0;
            is_instr    <= 1'b0;
        end else begin
            if (pop) noc_addr <= noc_addr + LOCAL_ADDR_W'(1);
            if (push && (axi_rlast != (burst_left == 9'd1))) error <= 1'b1;
            case (state)
                LD_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        is_instr  <= cmd_is_instr;
                        noc_addr  <= cmd_dst_addr;
                        remaining <= cmd_len;
                        if (cmd_len == 16'd0) begin
                            state <= LD_DONE;
                        end else begin
                            axi_araddr  <= cmd_src_addr;
                            axi_arlen   <= 8'(nb_cmd - 16'd1);
                            axi_arvalid <= 1'b1;
                            state       <= LD_ADDR;
                        end
                    end
                end
                LD_ADDR: begin
                    if (axi_arvalid) begin
                        if (axi_arready) begin
                            axi_arvalid <= 1'b0;
                            remaining   <= remaining - (16'(axi_arlen) + 16'd1);
                            burst_left  <= 9'(axi_arlen) + 9'd1;
                            state       <= LD_DATA;
                        end
                    end else if (free_next >= 17'(nb_cur)) begin
                        axi_arlen   <= 8'(nb_cur - 16'd1);
                        axi_arvalid <= 1'b1;
                    end
                end
                LD_DATA: begin
                    if (last_beat) begin
                        burst_left <= '0;
                        if (remaining != 16'd0) begin
                            axi_araddr  <= src_adv;
                            axi_arlen   <= 8'(nb_adv - 16'd1);
                            axi_arvalid <= (free_next >= 17'(nb_adv));
                            state       <= LD_ADDR;
                        end else begin
                            state <= LD_DRAIN;
                        end
                    end else if (push) begin
                        burst_left <= burst_left - 9'd1;
                    end
                end
                LD_DRAIN: begin
                    if (pop && (fifo_count == CW'(1))) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= LD_DONE;
                    end
                end
                LD_DONE: begin
                    // Zero-length commands arrive here with done low and pulse it one cycle later.
                    if (done) begin
                        done      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= LD_IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= LD_IDLE;
            endcase
        end
    end
endmodule
